// File: rtl/if_id_pipe_reg.sv
// IF->ID pipeline register with a valid/ready handshake, flush, an optional
// one-entry skid buffer and a saturating stall counter.
module if_id_pipe_reg #(
  parameter int unsigned       PC_W     = 32,
  parameter int unsigned       INST_W   = 32,
  parameter logic [PC_W-1:0]   RESET_PC = '0,
  parameter logic [INST_W-1:0] NOP_INST = '0,
  parameter bit                SKID_EN  = 1'b1,
  parameter int unsigned       CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INST_W-1:0] in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
  localparam logic [1:0] ST_SKID  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              valid_d;
  logic [PC_W-1:0]   pc_d, skid_pc_q, skid_pc_d;
  logic [INST_W-1:0] inst_d, skid_inst_q, skid_inst_d;
  logic [CNT_W-1:0]  stall_d;
  logic              tin, tout;

  // With the skid buffer, in_ready depends only on the state register.
  if (SKID_EN) begin : g_skid
    assign in_ready = rst & (state_q != ST_SKID);
  end else begin : g_noskid
    assign in_ready = rst & (~out_valid | out_ready);
  end

  assign tin  = in_valid & in_ready;
  assign tout = out_valid & out_ready;

  // Next-state and next-payload logic.
  always_comb begin
    state_d     = state_q;
    valid_d     = out_valid;
    pc_d        = out_pc;
    inst_d      = out_inst;
    skid_pc_d   = skid_pc_q;
    skid_inst_d = skid_inst_q;

    if (flush) begin
      state_d = ST_EMPTY;
      valid_d = 1'b0;
      inst_d  = NOP_INST;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (tin) begin
            state_d = ST_FULL;
            valid_d = 1'b1;
            pc_d    = in_pc;
            inst_d  = in_inst;
          end
        end
        ST_FULL: begin
          if (tin && !tout) begin
            if (SKID_EN) begin
              state_d     = ST_SKID;
              skid_pc_d   = in_pc;
              skid_inst_d = in_inst;
            end
          end else if (tin && tout) begin
            pc_d   = in_pc;
            inst_d = in_inst;
          end else if (tout) begin
            state_d = ST_EMPTY;
            valid_d = 1'b0;
            inst_d  = NOP_INST;
          end
        end
        ST_SKID: begin
          if (tout) begin
            state_d = ST_FULL;
            pc_d    = skid_pc_q;
            inst_d  = skid_inst_q;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          valid_d = 1'b0;
          inst_d  = NOP_INST;
        end
      endcase
    end
  end

  // Saturating stall counter, independent of flush.
  always_comb begin
    stall_d = stall_cnt;
    if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_d = stall_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_EMPTY;
      out_valid   <= 1'b0;
      out_pc      <= RESET_PC;
      out_inst    <= NOP_INST;
      skid_pc_q   <= '0;
      skid_inst_q <= '0;
      stall_cnt   <= '0;
    end else begin
      state_q     <= state_d;
      out_valid   <= valid_d;
      out_pc      <= pc_d;
      out_inst    <= inst_d;
      skid_pc_q   <= skid_pc_d;
      skid_inst_q <= skid_inst_d;
      stall_cnt   <= stall_d;
    end
  end

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Bench for if_id_pipe_reg: a skid-buffered instance and a combinational-ready
// instance with a 2-bit stall counter, each tracked by its own scoreboard.
module tb_if_id_pipe_reg;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } pl_t;

  typedef struct {
    logic        iv;
    logic [31:0] pc;
    logic        ordy;
    logic        ir;
    logic        ov;
    logic [31:0] opc;
    int          st;
  } vec_t;

  logic        clk, rst;
  logic        fl_a, iv_a, ir_a, ov_a, or_a;
  logic [31:0] ipc_a, iinst_a, opc_a, oinst_a;
  logic [15:0] st_a;
  logic        fl_b, iv_b, ir_b, ov_b, or_b;
  logic [31:0] ipc_b, iinst_b, opc_b, oinst_b;
  logic [1:0]  st_b;

  int  n_cmp = 0;
  int  n_err = 0;
  bit  armed = 0;
  pl_t q_a[$];
  pl_t q_b[$];
  int  exp_st_a = 0;
  int  exp_st_b = 0;
  vec_t tbl[11];

  if_id_pipe_reg #(.PC_W(32), .INST_W(32), .RESET_PC(RPC), .NOP_INST(NOP),
                   .SKID_EN(1'b1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .flush(fl_a), .in_valid(iv_a), .in_ready(ir_a),
    .in_pc(ipc_a), .in_inst(iinst_a), .out_valid(ov_a), .out_ready(or_a),
    .out_pc(opc_a), .out_inst(oinst_a), .stall_cnt(st_a));

  if_id_pipe_reg #(.PC_W(32), .INST_W(32), .RESET_PC(RPC), .NOP_INST(NOP),
                   .SKID_EN(1'b0), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .flush(fl_b), .in_valid(iv_b), .in_ready(ir_b),
    .in_pc(ipc_b), .in_inst(iinst_b), .out_valid(ov_b), .out_ready(or_b),
    .out_pc(opc_b), .out_inst(oinst_b), .stall_cnt(st_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return 32'hA5A5_0000 ^ pc;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [31:0] pc, input logic r, input logic f);
    iv_a = v; ipc_a = pc; iinst_a = inst_of(pc); or_a = r; fl_a = f;
  endtask

  task automatic drive_b(input logic v, input logic [31:0] pc, input logic r, input logic f);
    iv_b = v; ipc_b = pc; iinst_b = inst_of(pc); or_b = r; fl_b = f;
  endtask

  // Scoreboard for dut_a: handshakes seen at negedge hold until the next posedge.
  always @(negedge clk) begin
    if (armed) begin
      if (!rst) chk("a_in_ready_in_reset", 32'(ir_a), 32'd0);
      chk("a_stall_cnt", 32'(st_a), 32'(exp_st_a));
      if (!ov_a) chk("a_bubble_inst", oinst_a, NOP);
      if (rst && ov_a && or_a) begin
        if (q_a.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL a_unexpected_out actual pc=%h required no output", opc_a);
        end else begin
          pl_t e;
          e = q_a.pop_front();
          chk("a_out_pc", opc_a, e.pc);
          chk("a_out_inst", oinst_a, e.inst);
        end
      end
    end
    if (!rst) begin
      q_a.delete();
      exp_st_a = 0;
    end else begin
      if (ov_a && !or_a && exp_st_a != 65535) exp_st_a++;
      if (fl_a) q_a.delete();
      else if (iv_a && ir_a) q_a.push_back('{ipc_a, iinst_a});
    end
  end

  // Scoreboard for dut_b.
  always @(negedge clk) begin
    if (armed) begin
      if (!rst) chk("b_in_ready_in_reset", 32'(ir_b), 32'd0);
      chk("b_stall_cnt", 32'(st_b), 32'(exp_st_b));
      if (!ov_b) chk("b_bubble_inst", oinst_b, NOP);
      if (rst && ov_b && or_b) begin
        if (q_b.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL b_unexpected_out actual pc=%h required no output", opc_b);
        end else begin
          pl_t e;
          e = q_b.pop_front();
          chk("b_out_pc", opc_b, e.pc);
          chk("b_out_inst", oinst_b, e.inst);
        end
      end
    end
    if (!rst) begin
      q_b.delete();
      exp_st_b = 0;
    end else begin
      if (ov_b && !or_b && exp_st_b != 3) exp_st_b++;
      if (fl_b) q_b.delete();
      else if (iv_b && ir_b) q_b.push_back('{ipc_b, iinst_b});
    end
  end

  initial begin
    // {in_valid, in_pc, out_ready} -> {in_ready, out_valid, out_pc, stall_cnt} before the edge
    tbl[0]  = '{1'b1, 32'h00, 1'b1, 1'b1, 1'b0, RPC,    0};
    tbl[1]  = '{1'b1, 32'h04, 1'b1, 1'b1, 1'b1, 32'h00, 0};
    tbl[2]  = '{1'b1, 32'h08, 1'b1, 1'b1, 1'b1, 32'h04, 0};
    tbl[3]  = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'h08, 0};
    tbl[4]  = '{1'b1, 32'h10, 1'b0, 1'b1, 1'b0, 32'h08, 0};
    tbl[5]  = '{1'b1, 32'h14, 1'b0, 1'b1, 1'b1, 32'h10, 0};
    tbl[6]  = '{1'b1, 32'h18, 1'b0, 1'b0, 1'b1, 32'h10, 1};
    tbl[7]  = '{1'b1, 32'h18, 1'b0, 1'b0, 1'b1, 32'h10, 2};
    tbl[8]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 32'h10, 3};
    tbl[9]  = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'h14, 3};
    tbl[10] = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 32'h14, 3};

    rst = 1'b0;
    drive_a(1'b0, 32'h0, 1'b0, 1'b0);
    drive_b(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    chk("a_in_ready_held_reset", 32'(ir_a), 32'd0);
    rst = 1'b1;
    armed = 1'b1;
    #1;
    chk("a_reset_out_valid", 32'(ov_a), 32'd0);
    chk("a_reset_out_pc", opc_a, RPC);
    chk("a_reset_out_inst", oinst_a, NOP);
    chk("a_reset_stall", 32'(st_a), 32'd0);
    chk("a_in_ready_after_reset", 32'(ir_a), 32'd1);
    chk("b_reset_out_pc", opc_b, RPC);

    // Streaming and backpressure from the vector table.
    for (int i = 0; i < 11; i++) begin
      drive_a(tbl[i].iv, tbl[i].pc, tbl[i].ordy, 1'b0);
      #1;
      chk($sformatf("a_vec%0d_in_ready", i), 32'(ir_a), 32'(tbl[i].ir));
      chk($sformatf("a_vec%0d_out_valid", i), 32'(ov_a), 32'(tbl[i].ov));
      chk($sformatf("a_vec%0d_out_pc", i), opc_a, tbl[i].opc);
      chk($sformatf("a_vec%0d_stall", i), 32'(st_a), 32'(tbl[i].st));
      tick();
    end

    // Flush while SKID is occupied, with 0x20 offered in the same cycle.
    drive_a(1'b1, 32'h30, 1'b0, 1'b0); tick();
    drive_a(1'b1, 32'h34, 1'b0, 1'b0); tick();
    #1;
    chk("a_skid_in_ready", 32'(ir_a), 32'd0);
    drive_a(1'b1, 32'h20, 1'b0, 1'b1); tick();
    drive_a(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("a_flush_out_valid", 32'(ov_a), 32'd0);
    chk("a_flush_out_inst", oinst_a, NOP);
    chk("a_flush_out_pc_holds", opc_a, 32'h30);
    chk("a_flush_in_ready", 32'(ir_a), 32'd1);
    drive_a(1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) tick();

    // Flush coinciding with a transfer-out: 0x50 is consumed, nothing follows.
    drive_a(1'b1, 32'h50, 1'b1, 1'b0); tick();
    drive_a(1'b1, 32'h54, 1'b1, 1'b1); tick();
    drive_a(1'b0, 32'h0, 1'b1, 1'b0);
    #1;
    chk("a_flush_tout_out_valid", 32'(ov_a), 32'd0);
    tick(); tick();

    // Reset mid-stream with the skid occupied.
    drive_a(1'b1, 32'h60, 1'b0, 1'b0); tick();
    drive_a(1'b1, 32'h64, 1'b0, 1'b0); tick();
    rst = 1'b0;
    drive_a(1'b1, 32'h68, 1'b0, 1'b0);
    #1;
    chk("a_mid_reset_in_ready", 32'(ir_a), 32'd0);
    tick();
    rst = 1'b1;
    drive_a(1'b0, 32'h0, 1'b1, 1'b0);
    #1;
    chk("a_mid_reset_out_valid", 32'(ov_a), 32'd0);
    chk("a_mid_reset_out_pc", opc_a, RPC);
    chk("a_mid_reset_stall", 32'(st_a), 32'd0);
    chk("a_mid_reset_in_ready_after", 32'(ir_a), 32'd1);
    tick(); tick();

    // No-skid instance: hold 0x40 for six stalled cycles, counter saturates at 3.
    drive_b(1'b1, 32'h40, 1'b0, 1'b0);
    #1;
    chk("b_empty_in_ready", 32'(ir_b), 32'd1);
    tick();
    for (int i = 0; i < 6; i++) begin
      drive_b(1'b1, 32'h48, 1'b0, 1'b0);
      #1;
      chk($sformatf("b_stall%0d_in_ready", i), 32'(ir_b), 32'd0);
      chk($sformatf("b_stall%0d_out_pc", i), opc_b, 32'h40);
      tick();
    end
    chk("b_stall_saturated", 32'(st_b), 32'd3);
    drive_b(1'b1, 32'h44, 1'b1, 1'b0);
    #1;
    chk("b_same_cycle_in_ready", 32'(ir_b), 32'd1);
    chk("b_out_pc_before", opc_b, 32'h40);
    tick();
    drive_b(1'b0, 32'h0, 1'b1, 1'b0);
    #1;
    chk("b_next_out_valid", 32'(ov_b), 32'd1);
    chk("b_next_out_pc", opc_b, 32'h44);
    tick(); tick();
    chk("b_stall_held", 32'(st_b), 32'd3);
    chk("b_after_drain_out_valid", 32'(ov_b), 32'd0);

    chk("a_queue_drained", 32'(q_a.size()), 32'd0);
    chk("b_queue_drained", 32'(q_b.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
